// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD widths, FSM state type and digit validity helper
package bcd_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic {S_IDLE, S_RUN} state_t;
    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction
endpackage

// File: rtl/div5bcd_serial_if.sv
// div5bcd_serial_if: digit-in / quotient-out valid-ready bundle
//   in_*  : BCD digit stream (MSD first) from source to divider
//   out_* : quotient digit, last flag, remainder and error from divider to sink
//   slave : divider side, master : source/sink side
interface div5bcd_serial_if;
    import bcd_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [BCD_W-1:0] in_digit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BCD_W-1:0] out_digit;
    logic             out_last;
    logic [2:0]       out_rem;
    logic             out_err;
    modport slave (
        input  in_valid, in_digit, in_last, out_ready,
        output in_ready, out_valid, out_digit, out_last, out_rem, out_err
    );
    modport master (
        output in_valid, in_digit, in_last, out_ready,
        input  in_ready, out_valid, out_digit, out_last, out_rem, out_err
    );
endinterface

// File: rtl/bcd_div5_step.sv
// bcd_div5_step: one long-division step of a BCD number by 5
//   r      : incoming partial remainder (0..4)
//   d      : current digit
//   q      : quotient digit (0..9), 0 for a non-BCD digit
//   r_next : outgoing remainder; unchanged across a non-BCD digit
//   bad    : d is not a BCD digit
module bcd_div5_step
    import bcd_pkg::*;
(
    input  logic [2:0]       r,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic [2:0]       r_next,
    output logic             bad
);
    logic             hi;
    logic [BCD_W-1:0] lo;
    always_comb begin
        bad    = !is_bcd(d);
        hi     = d >= 4'd5;
        lo     = d - (hi ? 4'd5 : 4'd0);
        // (10r + d) / 5 = 2r + (d >= 5), which is just r shifted left with hi appended
        q      = bad ? 4'd0 : {r, hi};
        r_next = bad ? r : lo[2:0];
    end
endmodule

// File: rtl/div5bcd_serial.sv
// div5bcd_serial: serial MSD-first BCD divide-by-5 with one-cycle latency
//   clk   : clock, rising edge
//   rst_b : synchronous reset, active-low
//   bus   : slave side of div5bcd_serial_if (digit in, quotient/remainder out)
//   NDIG  : maximum digits per number; the NDIG-th digit ends the number
module div5bcd_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst_b,
    div5bcd_serial_if.slave     bus
);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [BCD_W-1:0] out_digit_q, out_digit_d;
    logic             out_last_q, out_last_d;
    logic [2:0]       out_rem_q, out_rem_d;
    logic             out_err_q, out_err_d;
    logic [BCD_W-1:0] q;
    logic [2:0]       r_next;
    logic             bad;
    logic             acc;
    logic             last;
    bcd_div5_step u_step (
        .r      (rem_q),
        .d      (bus.in_digit),
        .q      (q),
        .r_next (r_next),
        .bad    (bad)
    );
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_digit = out_digit_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_rem   = out_rem_q;
    assign bus.out_err   = out_err_q;
    always_comb begin
        acc         = bus.in_valid && bus.in_ready;
        last        = bus.in_last || (cnt_q == CW'(NDIG - 1));
        state_d     = state_q;
        rem_d       = rem_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_digit_d = out_digit_q;
        out_last_d  = out_last_q;
        out_rem_d   = out_rem_q;
        out_err_d   = out_err_q;
        if (acc) begin
            state_d     = last ? S_IDLE : S_RUN;
            rem_d       = last ? 3'd0 : r_next;
            err_d       = !last && (err_q || bad);
            cnt_d       = last ? '0 : cnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_digit_d = q;
            out_last_d  = last;
            out_rem_d   = last ? r_next : 3'd0;
            out_err_d   = last && (err_q || bad);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_last_q  <= 1'b0;
            out_rem_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_last_q  <= out_last_d;
            out_rem_q   <= out_rem_d;
            out_err_q   <= out_err_d;
        end
    end
endmodule

// File: tb/tb_div5bcd_serial.sv
// tb_div5bcd_serial: directed + randomized check of div5bcd_serial against an arithmetic model
module tb_div5bcd_serial;
    localparam int NDIG = 4;
    typedef struct {logic [3:0] d; logic l;} beat_t;
    typedef struct {logic [3:0] d; logic l; logic [2:0] r; logic e;} exp_t;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    div5bcd_serial_if bus();
    div5bcd_serial #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_fail = 0;
    beat_t src_q[$];
    exp_t  exp_q[$];
    int vpct = 100;
    int rpct = 100;
    int m_val = 0;
    int m_cnt = 0;
    logic m_err = 1'b0;
    logic held_v = 1'b0;
    exp_t held;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask
    // Expected output for one accepted digit: long division of the value seen so far
    // (non-BCD digits are skipped in the value) by 5, using plain integer arithmetic.
    function automatic exp_t model(input beat_t b);
        exp_t e;
        int prev;
        logic bad, last;
        bad  = b.d > 9;
        last = b.l || (m_cnt == NDIG - 1);
        prev = m_val;
        if (!bad) m_val = m_val * 10 + int'(b.d);
        e.d = bad ? 4'd0 : 4'(m_val / 5 - 10 * (prev / 5));
        e.l = last;
        e.r = last ? 3'(m_val % 5) : 3'd0;
        e.e = last && (m_err || bad);
        m_err = m_err || bad;
        m_cnt++;
        if (last) begin
            m_val = 0;
            m_cnt = 0;
            m_err = 1'b0;
        end
        return e;
    endfunction
    always @(negedge clk) begin
        if (!rst_b) begin
            held_v = 1'b0;
        end else begin
            check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (held_v) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_digit", bus.out_digit, held.d);
                check("hold_last", bus.out_last, held.l);
                check("hold_rem", bus.out_rem, held.r);
                check("hold_err", bus.out_err, held.e);
            end
            held_v = bus.out_valid && !bus.out_ready;
            held = '{bus.out_digit, bus.out_last, bus.out_rem, bus.out_err};
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_digit", bus.out_digit, e.d);
                    check("out_last", bus.out_last, e.l);
                    check("out_rem", bus.out_rem, e.r);
                    check("out_err", bus.out_err, e.e);
                end
            end
            if (bus.in_valid && bus.in_ready && src_q.size() > 0)
                exp_q.push_back(model(src_q.pop_front()));
        end
    end
    task automatic cycle();
        @(posedge clk);
        #1;
        bus.in_valid  = (src_q.size() > 0) && ($urandom_range(99) < vpct);
        bus.in_digit  = (src_q.size() > 0) ? src_q[0].d : 4'd0;
        bus.in_last   = (src_q.size() > 0) ? src_q[0].l : 1'b0;
        bus.out_ready = $urandom_range(99) < rpct;
    endtask
    task automatic drain();
        int k = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && k < 2000) begin
            cycle();
            k++;
        end
        check("drain_timeout", k < 2000, 1);
    endtask
    task automatic push(input logic [3:0] d, input logic l);
        src_q.push_back('{d, l});
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        src_q.delete();
        exp_q.delete();
        m_val = 0;
        m_cnt = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_digit  = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_digit", bus.out_digit, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_rem", bus.out_rem, 0);
        check("rst_err", bus.out_err, 0);
        push(3, 0); push(7, 1);
        drain();
        push(4, 0); push(9, 0); push(9, 1);
        drain();
        push(5, 1); push(2, 1);
        drain();
        push(1, 0); push(2, 0); push(3, 0); push(6, 1);
        repeat (2) cycle();
        rpct = 0;
        repeat (3) cycle();
        rpct = 100;
        drain();
        push(1, 0); push(12, 0); push(4, 1);
        drain();
        push(1, 0); push(2, 0); push(3, 0); push(4, 0); push(5, 0); push(6, 1);
        drain();
        push(7, 0); push(8, 0);
        drain();
        push(9, 0);
        cycle();
        while (src_q.size() > 0) cycle();
        do_reset();
        @(negedge clk);
        check("rst_mid_valid", bus.out_valid, 0);
        push(2, 1);
        drain();
        vpct = 70;
        rpct = 70;
        for (int n = 0; n < 200; n++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++)
                push(($urandom_range(9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)), j == len - 1);
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
